// File: rtl/ddr_clk_gen.sv
// Derives the half-rate DDR clock from the fast write clock by even division, and drives a
// glitch-free gated CLK_P/CLK_N pair, a lock indication and rising/falling phase strobes.
module ddr_clk_gen #(
  parameter int CLK_DIV     = 2,
  parameter int LOCK_CYCLES = 67
) (
  input  logic WR_CLK_333M,
  input  logic RESET_N,
  output logic DDR_CLK_166M,
  output logic CLK_P,
  output logic CLK_N,
  output logic LOCKED,
  output logic OUT_EN,
  output logic PH_RISE,
  output logic PH_FALL
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [15:0]      LOCK_TGT = 16'(LOCK_CYCLES);

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [15:0]      lock_cnt_r, lock_cnt_nxt_s;
  logic             ddr_r, ddr_nxt_s;
  logic             toggle_s, rise_s, fall_s;
  logic             locked_r, locked_nxt_s;
  logic             out_en_r, out_en_nxt_s;
  logic             clk_p_r, clk_p_nxt_s;
  logic             clk_n_r, clk_n_nxt_s;
  logic             ph_rise_r, ph_fall_r;

  // Next-state logic for divider, strobes, lock counter, output enable and the pair
  always_comb begin
    cnt_nxt_s      = cnt_r;
    lock_cnt_nxt_s = lock_cnt_r;
    clk_p_nxt_s    = 1'b0;
    clk_n_nxt_s    = 1'b1;

    if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end

    // Toggling on counts 0 and CLK_DIV/2 makes the first edge out of reset a rising one
    toggle_s  = (cnt_r == CNT_ZERO) || (cnt_r == CNT_HALF);
    ddr_nxt_s = ddr_r ^ toggle_s;
    rise_s    = toggle_s & ~ddr_r;
    fall_s    = toggle_s & ddr_r;

    if (lock_cnt_r != LOCK_TGT) begin
      lock_cnt_nxt_s = lock_cnt_r + 16'd1;
    end else begin
      lock_cnt_nxt_s = lock_cnt_r;
    end
    locked_nxt_s = locked_r | (lock_cnt_nxt_s == LOCK_TGT);

    // Enable only on a rising DDR edge once already locked, so the pair opens on a full high phase
    out_en_nxt_s = out_en_r | (locked_r & rise_s);

    if (out_en_nxt_s) begin
      clk_p_nxt_s = ddr_nxt_s;
      clk_n_nxt_s = ~ddr_nxt_s;
    end else begin
      clk_p_nxt_s = 1'b0;
      clk_n_nxt_s = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge WR_CLK_333M or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r      <= CNT_ZERO;
      lock_cnt_r <= 16'd0;
      ddr_r      <= 1'b0;
      locked_r   <= 1'b0;
      out_en_r   <= 1'b0;
      clk_p_r    <= 1'b0;
      clk_n_r    <= 1'b1;
      ph_rise_r  <= 1'b0;
      ph_fall_r  <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      ddr_r      <= ddr_nxt_s;
      locked_r   <= locked_nxt_s;
      out_en_r   <= out_en_nxt_s;
      clk_p_r    <= clk_p_nxt_s;
      clk_n_r    <= clk_n_nxt_s;
      ph_rise_r  <= rise_s;
      ph_fall_r  <= fall_s;
    end
  end

  assign DDR_CLK_166M = ddr_r;
  assign CLK_P        = clk_p_r;
  assign CLK_N        = clk_n_r;
  assign LOCKED       = locked_r;
  assign OUT_EN       = out_en_r;
  assign PH_RISE      = ph_rise_r;
  assign PH_FALL      = ph_fall_r;

endmodule

// File: tb/tb_ddr_clk_gen.sv
// Directed bench for ddr_clk_gen: one instance at CLK_DIV=2, one at CLK_DIV=6, shared clock/reset.
module tb_ddr_clk_gen;

  logic clk;
  logic rst_n;
  logic u2_ddr, u2_p, u2_n, u2_lock, u2_en, u2_rise, u2_fall;
  logic u6_ddr, u6_p, u6_n, u6_lock, u6_en, u6_rise, u6_fall;

  int errors;
  int checks;
  int edge_n;

  ddr_clk_gen #(.CLK_DIV(2), .LOCK_CYCLES(67)) u_div2 (
    .WR_CLK_333M (clk),
    .RESET_N     (rst_n),
    .DDR_CLK_166M(u2_ddr),
    .CLK_P       (u2_p),
    .CLK_N       (u2_n),
    .LOCKED      (u2_lock),
    .OUT_EN      (u2_en),
    .PH_RISE     (u2_rise),
    .PH_FALL     (u2_fall)
  );

  ddr_clk_gen #(.CLK_DIV(6), .LOCK_CYCLES(67)) u_div6 (
    .WR_CLK_333M (clk),
    .RESET_N     (rst_n),
    .DDR_CLK_166M(u6_ddr),
    .CLK_P       (u6_p),
    .CLK_N       (u6_n),
    .LOCKED      (u6_lock),
    .OUT_EN      (u6_en),
    .PH_RISE     (u6_rise),
    .PH_FALL     (u6_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n = edge_n + 1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    checks = checks + 7;
    if (u2_ddr !== 1'b0)  begin errors = errors + 1; $display("FAIL reset_ddr: got %b expected 0", u2_ddr); end
    if (u2_p !== 1'b0)    begin errors = errors + 1; $display("FAIL reset_clk_p: got %b expected 0", u2_p); end
    if (u2_n !== 1'b1)    begin errors = errors + 1; $display("FAIL reset_clk_n: got %b expected 1", u2_n); end
    if (u2_lock !== 1'b0) begin errors = errors + 1; $display("FAIL reset_locked: got %b expected 0", u2_lock); end
    if (u2_en !== 1'b0)   begin errors = errors + 1; $display("FAIL reset_out_en: got %b expected 0", u2_en); end
    if (u2_rise !== 1'b0) begin errors = errors + 1; $display("FAIL reset_ph_rise: got %b expected 0", u2_rise); end
    if (u2_fall !== 1'b0) begin errors = errors + 1; $display("FAIL reset_ph_fall: got %b expected 0", u2_fall); end
  endtask

  task automatic test_div2();
    logic exp_ddr;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_ddr = (i % 2) == 1;
      checks = checks + 3;
      if (u2_ddr !== exp_ddr)   begin errors = errors + 1; $display("FAIL div2_ddr edge %0d: got %b expected %b", i, u2_ddr, exp_ddr); end
      if (u2_rise !== exp_ddr)  begin errors = errors + 1; $display("FAIL div2_ph_rise edge %0d: got %b expected %b", i, u2_rise, exp_ddr); end
      if (u2_fall !== !exp_ddr) begin errors = errors + 1; $display("FAIL div2_ph_fall edge %0d: got %b expected %b", i, u2_fall, !exp_ddr); end
    end
  endtask

  task automatic test_lock();
    while (edge_n < 69) begin
      tick();
      if (edge_n == 66) begin
        checks = checks + 1;
        if (u2_lock !== 1'b0) begin errors = errors + 1; $display("FAIL lock_66: got %b expected 0", u2_lock); end
      end
      if (edge_n == 67) begin
        checks = checks + 2;
        if (u2_lock !== 1'b1) begin errors = errors + 1; $display("FAIL lock_67: got %b expected 1", u2_lock); end
        if (u2_en !== 1'b0)   begin errors = errors + 1; $display("FAIL out_en_67: got %b expected 0", u2_en); end
      end
      if (edge_n == 68) begin
        checks = checks + 1;
        if (u2_en !== 1'b0) begin errors = errors + 1; $display("FAIL out_en_68: got %b expected 0", u2_en); end
      end
      if (edge_n == 69) begin
        checks = checks + 3;
        if (u2_en !== 1'b1) begin errors = errors + 1; $display("FAIL out_en_69: got %b expected 1", u2_en); end
        if (u2_p !== 1'b1)  begin errors = errors + 1; $display("FAIL clk_p_69: got %b expected 1", u2_p); end
        if (u2_n !== 1'b0)  begin errors = errors + 1; $display("FAIL clk_n_69: got %b expected 0", u2_n); end
      end
    end
  endtask

  task automatic test_steady();
    logic exp_ddr;
    for (int i = 0; i < 100; i++) begin
      tick();
      exp_ddr = edge_n[0];
      checks = checks + 6;
      if (u2_ddr !== exp_ddr)  begin errors = errors + 1; $display("FAIL steady_ddr edge %0d: got %b expected %b", edge_n, u2_ddr, exp_ddr); end
      if (u2_p !== exp_ddr)    begin errors = errors + 1; $display("FAIL steady_clk_p edge %0d: got %b expected %b", edge_n, u2_p, exp_ddr); end
      if (u2_n !== !exp_ddr)   begin errors = errors + 1; $display("FAIL steady_clk_n edge %0d: got %b expected %b", edge_n, u2_n, !exp_ddr); end
      if (u2_lock !== 1'b1)    begin errors = errors + 1; $display("FAIL steady_locked edge %0d: got %b expected 1", edge_n, u2_lock); end
      if (u2_rise !== exp_ddr) begin errors = errors + 1; $display("FAIL steady_ph_rise edge %0d: got %b expected %b", edge_n, u2_rise, exp_ddr); end
      if (u2_fall !== !exp_ddr) begin errors = errors + 1; $display("FAIL steady_ph_fall edge %0d: got %b expected %b", edge_n, u2_fall, !exp_ddr); end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    test_reset();
    checks = checks + 3;
    if (u6_ddr !== 1'b0)  begin errors = errors + 1; $display("FAIL async_div6_ddr: got %b expected 0", u6_ddr); end
    if (u6_lock !== 1'b0) begin errors = errors + 1; $display("FAIL async_div6_locked: got %b expected 0", u6_lock); end
    if (u6_n !== 1'b1)    begin errors = errors + 1; $display("FAIL async_div6_clk_n: got %b expected 1", u6_n); end
  endtask

  task automatic test_div6();
    logic [11:0] exp_ddr;
    logic [11:0] exp_rise;
    logic [11:0] exp_fall;
    exp_ddr  = 12'b000111000111;
    exp_rise = 12'b000001000001;
    exp_fall = 12'b001000001000;
    release_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks = checks + 5;
      if (u6_ddr !== exp_ddr[i])   begin errors = errors + 1; $display("FAIL div6_ddr edge %0d: got %b expected %b", i + 1, u6_ddr, exp_ddr[i]); end
      if (u6_rise !== exp_rise[i]) begin errors = errors + 1; $display("FAIL div6_ph_rise edge %0d: got %b expected %b", i + 1, u6_rise, exp_rise[i]); end
      if (u6_fall !== exp_fall[i]) begin errors = errors + 1; $display("FAIL div6_ph_fall edge %0d: got %b expected %b", i + 1, u6_fall, exp_fall[i]); end
      if (u6_p !== 1'b0)           begin errors = errors + 1; $display("FAIL div6_clk_p edge %0d: got %b expected 0", i + 1, u6_p); end
      if (u6_n !== 1'b1)           begin errors = errors + 1; $display("FAIL div6_clk_n edge %0d: got %b expected 1", i + 1, u6_n); end
    end
  endtask

  task automatic test_reset_relock();
    @(negedge clk);
    rst_n = 1'b0;
    release_reset();
    while (edge_n < 30) tick();
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (u2_lock !== 1'b0) begin errors = errors + 1; $display("FAIL relock_in_reset: got %b expected 0", u2_lock); end
    release_reset();
    while (edge_n < 67) begin
      tick();
      if (edge_n == 37 || edge_n == 66) begin
        checks = checks + 1;
        if (u2_lock !== 1'b0) begin errors = errors + 1; $display("FAIL relock_early edge %0d: got %b expected 0", edge_n, u2_lock); end
      end
    end
    checks = checks + 2;
    if (u2_lock !== 1'b1) begin errors = errors + 1; $display("FAIL relock_67: got %b expected 1", u2_lock); end
    if (u6_lock !== 1'b1) begin errors = errors + 1; $display("FAIL relock_div6_67: got %b expected 1", u6_lock); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    edge_n = 0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    release_reset();
    test_div2();
    test_lock();
    test_steady();
    test_async_reset();
    test_div6();
    test_reset_relock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
